// File: rtl/controller_fsm_param_if.sv
// Control bus between the controller FSM and the CPU datapath (IR, PC, memory, RF, ALU).
// Controller side is the master; the datapath side is the slave.
interface controller_fsm_param_if #(
    parameter int IW   = 16,
    parameter int DAW  = 8,
    parameter int RFAW = 4,
    parameter int PCW  = 8,
    parameter int CNTW = 16
);
    logic [IW-1:0]   instruction;
    logic            RFAZero;
    logic            Resume;
    logic            PCClr;
    logic            PCUp;
    logic            PCLd;
    logic [PCW-1:0]  PCTarget;
    logic            IRLd;
    logic [DAW-1:0]  DAddr;
    logic            DWrite;
    logic            RFSelect;
    logic [RFAW-1:0] RFWriteAddr;
    logic            RFWriteEnable;
    logic [RFAW-1:0] RFAReadAddr;
    logic [RFAW-1:0] RFBReadAddr;
    logic [2:0]      ALUSelect;
    logic            Illegal;
    logic            Halted;
    logic [CNTW-1:0] InstrCount;
    logic [3:0]      CurrentStateOut;
    logic [3:0]      NextStateOut;

    modport master (
        input  instruction, RFAZero, Resume,
        output PCClr, PCUp, PCLd, PCTarget, IRLd, DAddr, DWrite, RFSelect,
               RFWriteAddr, RFWriteEnable, RFAReadAddr, RFBReadAddr, ALUSelect,
               Illegal, Halted, InstrCount, CurrentStateOut, NextStateOut
    );

    modport slave (
        output instruction, RFAZero, Resume,
        input  PCClr, PCUp, PCLd, PCTarget, IRLd, DAddr, DWrite, RFSelect,
               RFWriteAddr, RFWriteEnable, RFAReadAddr, RFBReadAddr, ALUSelect,
               Illegal, Halted, InstrCount, CurrentStateOut, NextStateOut
    );
endinterface

// File: rtl/controller_fsm_param.sv
// Parametrised CPU controller: fetch/decode FSM with counted load wait, branches, HALT and TRAP.
// Outputs are combinational from state and instruction; only InstrCount is registered.
module controller_fsm_param #(
    parameter int IW        = 16,
    parameter int DAW       = 8,
    parameter int RFAW      = 4,
    parameter int PCW       = 8,
    parameter int LOAD_WAIT = 1,
    parameter int CNTW      = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    controller_fsm_param_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT   = 4'b1000,
        S_FETCH  = 4'b1111,
        S_DECODE = 4'b1100,
        S_NOOP   = 4'b0000,
        S_STORE  = 4'b0001,
        S_LOAD_A = 4'b0010,
        S_ADD    = 4'b0011,
        S_SUB    = 4'b0100,
        S_HALT   = 4'b0101,
        S_LOAD_B = 4'b0110,
        S_JMP    = 4'b0111,
        S_JZ     = 4'b1001,
        S_TRAP   = 4'b1010
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(LOAD_WAIT - 1);

    state_t          state, nstate;
    logic [3:0]      wait_cnt;
    logic [CNTW-1:0] instr_cnt;

    logic [3:0]      opcode;
    logic [DAW-1:0]  la, sd;
    logic [RFAW-1:0] ra, rb, rw, jz_ra;
    logic [PCW-1:0]  tgt;

    assign opcode = bus.instruction[IW-1 -: 4];
    assign la     = bus.instruction[DAW+RFAW-1:RFAW];
    assign sd     = bus.instruction[DAW-1:0];
    assign ra     = bus.instruction[3*RFAW-1:2*RFAW];
    assign rb     = bus.instruction[2*RFAW-1:RFAW];
    assign rw     = bus.instruction[RFAW-1:0];
    assign jz_ra  = bus.instruction[IW-5 -: RFAW];
    assign tgt    = bus.instruction[PCW-1:0];

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_INIT;
        else     state <= nstate;
    end

    // Wait counter is zero whenever we are outside LOAD_A, so it enters LOAD_A at 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            wait_cnt <= (state == S_LOAD_A) ? wait_cnt + 4'd1 : 4'd0;
            if (state == S_DECODE) instr_cnt <= instr_cnt + CNTW'(1);
        end
    end

    always_comb begin
        nstate = S_INIT;
        case (state)
            S_INIT:   nstate = S_FETCH;
            S_FETCH:  nstate = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'd0:    nstate = S_NOOP;
                    4'd1:    nstate = S_STORE;
                    4'd2:    nstate = S_LOAD_A;
                    4'd3:    nstate = S_ADD;
                    4'd4:    nstate = S_SUB;
                    4'd5:    nstate = S_HALT;
                    4'd6:    nstate = S_JMP;
                    4'd7:    nstate = S_JZ;
                    default: nstate = S_TRAP;
                endcase
            end
            S_LOAD_A: nstate = (wait_cnt == WAIT_LAST) ? S_LOAD_B : S_LOAD_A;
            S_HALT:   nstate = bus.Resume ? S_FETCH : S_HALT;
            S_NOOP, S_STORE, S_ADD, S_SUB, S_LOAD_B, S_JMP, S_JZ, S_TRAP:
                      nstate = S_FETCH;
            default:  nstate = S_INIT;
        endcase
    end

    always_comb begin
        bus.PCClr         = 1'b0;
        bus.PCUp          = 1'b0;
        bus.PCLd          = 1'b0;
        bus.PCTarget      = '0;
        bus.IRLd          = 1'b0;
        bus.DAddr         = '0;
        bus.DWrite        = 1'b0;
        bus.RFSelect      = 1'b0;
        bus.RFWriteAddr   = '0;
        bus.RFWriteEnable = 1'b0;
        bus.RFAReadAddr   = '0;
        bus.RFBReadAddr   = '0;
        bus.ALUSelect     = 3'b000;
        bus.Illegal       = 1'b0;
        bus.Halted        = 1'b0;
        case (state)
            S_INIT:  bus.PCClr = 1'b1;
            S_FETCH: begin
                bus.PCUp = 1'b1;
                bus.IRLd = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                bus.DAddr         = la;
                bus.RFSelect      = 1'b1;
                bus.RFWriteAddr   = rw;
                bus.RFWriteEnable = (state == S_LOAD_B);
            end
            S_STORE: begin
                bus.DAddr       = sd;
                bus.RFAReadAddr = ra;
                bus.DWrite      = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RFAReadAddr   = ra;
                bus.RFBReadAddr   = rb;
                bus.RFWriteAddr   = rw;
                bus.RFWriteEnable = 1'b1;
                bus.ALUSelect     = (state == S_ADD) ? 3'b001 : 3'b010;
            end
            S_JMP: begin
                bus.PCLd     = 1'b1;
                bus.PCTarget = tgt;
            end
            // Conditional branch never increments the PC, even when not taken.
            S_JZ: begin
                bus.RFAReadAddr = jz_ra;
                bus.PCTarget    = tgt;
                bus.PCLd        = bus.RFAZero;
            end
            S_HALT:  bus.Halted  = 1'b1;
            S_TRAP:  bus.Illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.InstrCount      = instr_cnt;
    assign bus.CurrentStateOut = state;
    assign bus.NextStateOut    = nstate;
endmodule
